regfile_2w_sb: RTL
==================

# regfile_2w_sb

Parametrised two-write-port register file with per-register scoreboard for the RISC-V core, successor to the single-write-port integer register file. Provides two asynchronous read ports with same-cycle write forwarding and two synchronous write ports: port A for ALU writeback and port B for late load/long-latency writeback. An optional busy-bit scoreboard tracks registers with outstanding writes so issue logic can stall on RAW hazards. Sits between decode/issue and the writeback stage.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, at least 2
- AW, 5, address width; must equal log2(NREGS)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data, combinational
- rs2_data  out  XLEN  read port 2 data, combinational
- rs1_ready  out  1  rs1 has no pending write, or is written this cycle
- rs2_ready  out  1  same for rs2
- wa_en  in  1  write port A enable
- wa_addr  in  AW  write port A address
- wa_data  in  XLEN  write port A data
- wb_en  in  1  write port B enable
- wb_addr  in  AW  write port B address
- wb_data  in  XLEN  write port B data
- rsv_en  in  1  reserve request: mark rsv_addr as pending write
- rsv_addr  in  AW  register to reserve
- rsv_conflict  out  1  combinational: rsv_en && rsv_addr!=0 && rsv_addr already busy
- busy_count  out  AW+1  number of busy registers, registered

## Operation
- Register 0 reads as 0, ignores writes and is never busy.
- Write: on the rising edge, if wX_en && wX_addr!=0, the register takes wX_data. If both ports target the same address, port B wins.
- Read: rsN_data = 0 if rsN_addr==0; else wb_data on a port B hit (wb_en, matching address); else wa_data on a port A hit; else the array value. Port B has priority in forwarding as well.
- Scoreboard: one busy bit per register.
  - Set at the edge when rsv_en && rsv_addr!=0 && !busy[rsv_addr].
  - Cleared at the edge when either write port writes that address.
- Reserve and write to the same register in the same cycle: the reserve wins and busy stays 1, since it belongs to a newer producer.
- Reserving an already-busy register: rsv_conflict=1 and no state change. Issue logic must stall.
- rsN_ready = (rsN_addr==0) || !busy[rsN_addr] || a write port hits rsN_addr this cycle.
- busy_count is updated incrementally each cycle as +1 (accepted reserve) minus the number of distinct busy registers cleared, saturating at 0..NREGS-1. Both ports writing the same busy register counts as one clear. A write to a non-busy register does not decrement.

## Timing
- Reads and forwarding: zero-cycle combinational.
- Writes: visible from the array at cycle N+1, forwarded in cycle N.
- Reserve issued in cycle N: busy and ready reflect it from N+1. It is not visible to rsN_ready in cycle N.
- Reset (any cycle, including mid-operation): at the next edge all registers become 0, all busy bits 0 and busy_count 0. Writes and reserves presented in the reset cycle are discarded. Combinational outputs still forward during reset assertion.

## Configuration
- REGFILE_SCOREBOARD_EN defined: scoreboard, rsv_conflict and busy_count behave as above.
- Not defined: no busy bits or counter are built. rsv_en and rsv_addr are ignored, rs1_ready=rs2_ready=1, rsv_conflict=0, busy_count=0. Read, write and forwarding behaviour is unchanged.

## Test plan
- Reset, then write x5=0xDEADBEEF via port A → rs1_addr=5 returns 0xDEADBEEF in the same cycle (forwarded) and the next cycle (array). Write x0=0x1234 → x0 reads 0.
- Same cycle wa (x7=0x11) and wb (x7=0x22) → forwarded and stored value is 0x22.
- Reserve x3 at cycle 0 → rs1_ready(x3)=0 and busy_count=1 at cycle 1. wb writes x3=0x99 at cycle 4 → ready=1 and data 0x99 in cycle 4; busy_count=0 at cycle 5.
- Reserve x3 again while busy → rsv_conflict=1, busy_count unchanged. Reserve x4 and wa write x4 in the same cycle → x4 stays busy, busy_count increments.
- Reserve x1, x2, x6, then assert reset for one cycle with a concurrent reserve of x9 → all registers read 0, busy_count=0, all ready=1.
- Build without REGFILE_SCOREBOARD_EN: reserve x3 → ready stays 1, busy_count=0, rsv_conflict=0. Read/write tests still pass.

Source files
------------

// File: rtl/regfile_2w_sb.sv
// ============================================================================
// Module   : regfile_2w_sb
// Brief    : Two-write-port integer register file with combinational
//            forwarding reads and an optional busy-bit scoreboard
//            (enabled by defining REGFILE_SCOREBOARD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2w_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_ready,
    output logic            rs2_ready,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rsv_conflict,
    output logic [AW:0]     busy_count
);

    logic [XLEN-1:0] r_regs [NREGS];

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = (wa_en && wa_addr == rs1_addr) || (wb_en && wb_addr == rs1_addr);
    assign w_rs2_hit = (wa_en && wa_addr == rs2_addr) || (wb_en && wb_addr == rs2_addr);

    // Port B is assigned last so it wins a same-address collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (wa_en && wa_addr != '0) begin
                r_regs[wa_addr] <= wa_data;
            end
            if (wb_en && wb_addr != '0) begin
                r_regs[wb_addr] <= wb_data;
            end
        end
    end

    always_comb begin
        rs1_data = r_regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_en && wb_addr == rs1_addr) begin
            rs1_data = wb_data;
        end else if (wa_en && wa_addr == rs1_addr) begin
            rs1_data = wa_data;
        end
    end

    always_comb begin
        rs2_data = r_regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_en && wb_addr == rs2_addr) begin
            rs2_data = wb_data;
        end else if (wa_en && wa_addr == rs2_addr) begin
            rs2_data = wa_data;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN

    localparam logic [AW+1:0] c_CNT_MAX = (AW+2)'(NREGS - 1);

    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_count;

    logic            w_rsv_ok;
    logic            w_a_clr;
    logic            w_b_clr;
    logic [1:0]      w_dec;
    logic [AW+1:0]   w_up;
    logic [AW+1:0]   w_diff;
    logic [AW:0]     w_cnt_next;

    assign w_rsv_ok     = rsv_en && rsv_addr != '0 && !r_busy[rsv_addr];
    assign rsv_conflict = rsv_en && rsv_addr != '0 && r_busy[rsv_addr];

    assign rs1_ready = (rs1_addr == '0) || !r_busy[rs1_addr] || w_rs1_hit;
    assign rs2_ready = (rs2_addr == '0) || !r_busy[rs2_addr] || w_rs2_hit;

    // A register hit by both ports is cleared once, so port B only counts
    // when it targets a different busy register than port A.
    assign w_a_clr = wa_en && wa_addr != '0 && r_busy[wa_addr];
    assign w_b_clr = wb_en && wb_addr != '0 && r_busy[wb_addr]
                     && !(w_a_clr && wa_addr == wb_addr);
    assign w_dec   = {1'b0, w_a_clr} + {1'b0, w_b_clr};

    always_comb begin
        w_up       = {1'b0, r_busy_count} + {{(AW+1){1'b0}}, w_rsv_ok};
        w_diff     = w_up - {{AW{1'b0}}, w_dec};
        w_cnt_next = w_diff[AW:0];
        if (w_up < {{AW{1'b0}}, w_dec}) begin
            w_cnt_next = '0;
        end else if (w_diff > c_CNT_MAX) begin
            w_cnt_next = c_CNT_MAX[AW:0];
        end
    end

    // Clear first, then set: a same-cycle accepted reserve belongs to a
    // newer producer and must survive the older write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if ((wa_en && wa_addr == AW'(i)) || (wb_en && wb_addr == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
                if (w_rsv_ok && rsv_addr == AW'(i)) begin
                    r_busy[i] <= 1'b1;
                end
            end
            r_busy[0]    <= 1'b0;
            r_busy_count <= w_cnt_next;
        end
    end

    assign busy_count = r_busy_count;

`else

    logic w_unused_sb;

    assign w_unused_sb  = ^{rsv_en, rsv_addr, w_rs1_hit, w_rs2_hit};
    assign rs1_ready    = 1'b1;
    assign rs2_ready    = 1'b1;
    assign rsv_conflict = 1'b0;
    assign busy_count   = '0;

`endif

endmodule

`default_nettype wire
